// File: rtl/qif_pkg.sv
// Shared definitions for the QIF neuron, synapse and spike-decoder blocks.
package qif_pkg;

  // Datapath width used across the QIF blocks.
  localparam int QIF_DATA_W = 8;

  // Default decoder widths, shared with the neuron and the synapse blocks.
  localparam int QIF_CNT_W  = 8;   // spike-rate counter width
  localparam int QIF_WIN_W  = 16;  // window-length width
  localparam int QIF_ISI_W  = 16;  // inter-spike-interval timer width

  // Spike-rate decoder states.
  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } dec_state_e;

endpackage

// File: rtl/qif_sat_counter.sv
// Saturating up-counter with clear, load-to-1 and a saturation flag.
// CLR_MAX selects whether clear and reset go to all-ones instead of zero,
// so the same block serves the rate counter and the ISI timer.
module qif_sat_counter #(
  parameter int W       = 8,
  parameter bit CLR_MAX = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         load1_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o,
  output logic         sat_o
);

  localparam logic [W-1:0] MAX_VAL = '1;
  localparam logic [W-1:0] CLR_VAL = CLR_MAX ? MAX_VAL : '0;
  localparam logic [W-1:0] ONE     = W'(1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  assign sat_o   = (count_q == MAX_VAL);
  assign count_o = count_q;

  // Next count: clear wins over load-1, which wins over a saturating increment.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = CLR_VAL;
    end else if (load1_i) begin
      count_d = ONE;
    end else if (inc_i && !sat_o) begin
      count_d = count_q + ONE;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= CLR_VAL;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/qif_spike_rate_decoder.sv
// Receive side of the QIF spike interface: converts a 1-bit spike train into
// per-window spike counts plus the most recent inter-spike interval, and hands
// one result per window to a valid/ready consumer.
module qif_spike_rate_decoder
  import qif_pkg::*;
#(
  parameter int CNT_W = QIF_CNT_W,
  parameter int WIN_W = QIF_WIN_W,
  parameter int ISI_W = QIF_ISI_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             spike_in,
  input  logic [WIN_W-1:0] win_len,
  output logic [CNT_W-1:0] rate_out,
  output logic [ISI_W-1:0] isi_out,
  output logic             sat_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun
);

  localparam logic [WIN_W-1:0] WIN_ONE = WIN_W'(1);

  dec_state_e       state_q, state_d;
  logic             spike_q;
  logic [WIN_W-1:0] win_len_q, win_len_d;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic [ISI_W-1:0] isi_last_q, isi_last_d;

  logic [CNT_W-1:0] rate_out_q, rate_out_d;
  logic [ISI_W-1:0] isi_out_q, isi_out_d;
  logic             sat_out_q, sat_out_d;
  logic             out_valid_q, out_valid_d;
  logic             overrun_q, overrun_d;

  logic             spike_edge;
  logic             counting;
  logic             edge_cnt;
  logic             win_close;
  logic             load_result;
  logic [WIN_W-1:0] win_len_eff;

  logic [CNT_W-1:0] rate_cnt;
  logic             rate_sat;
  logic             rate_bump;
  logic [CNT_W-1:0] rate_incl;
  logic             sat_incl;

  logic [ISI_W-1:0] isi_timer;
  logic             isi_timer_sat;
  logic [ISI_W-1:0] isi_now;
  logic [ISI_W-1:0] isi_incl;

  // A held-high level counts once: only the rising edge is a spike.
  assign spike_edge  = spike_in & ~spike_q;
  assign counting    = (state_q == COUNT) && en;
  assign edge_cnt    = counting && spike_edge;
  assign win_len_eff = (win_len == '0) ? WIN_ONE : win_len;
  assign win_close   = counting && (win_cnt_q == (win_len_q - WIN_ONE));

  // Closing-window values include whatever edge arrives on the close cycle.
  assign rate_bump = edge_cnt & ~rate_sat;
  assign rate_incl = rate_cnt + CNT_W'(rate_bump);
  assign sat_incl  = (rate_incl == '1);

  // A saturated timer at an edge means no earlier spike since enable, so the
  // interval is reported as 0 until a second edge arrives.
  assign isi_now  = isi_timer_sat ? '0 : isi_timer;
  assign isi_incl = edge_cnt ? isi_now : isi_last_q;

  // Spike counter for the current window; restarts at every close.
  qif_sat_counter #(
    .W       (CNT_W),
    .CLR_MAX (1'b0)
  ) u_rate_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (!counting || win_close),
    .load1_i (1'b0),
    .inc_i   (edge_cnt),
    .count_o (rate_cnt),
    .sat_o   (rate_sat)
  );

  // Cycles since the last edge; runs across window boundaries.
  qif_sat_counter #(
    .W       (ISI_W),
    .CLR_MAX (1'b1)
  ) u_isi_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (!counting),
    .load1_i (edge_cnt),
    .inc_i   (counting),
    .count_o (isi_timer),
    .sat_o   (isi_timer_sat)
  );

  // Next state, window length/position and the retained interval.
  always_comb begin
    state_d    = state_q;
    win_len_d  = win_len_q;
    win_cnt_d  = win_cnt_q;
    isi_last_d = counting ? isi_incl : '0;
    case (state_q)
      IDLE: begin
        win_cnt_d = '0;
        if (en) begin
          state_d   = COUNT;
          win_len_d = win_len_eff;
        end
      end
      COUNT: begin
        if (!en) begin
          state_d   = IDLE;
          win_cnt_d = '0;
        end else if (win_close) begin
          win_cnt_d = '0;
          win_len_d = win_len_eff;
        end else begin
          win_cnt_d = win_cnt_q + WIN_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output register and handshake: a close only loads when the slot is free
  // or being drained this cycle; otherwise the result is dropped and flagged.
  always_comb begin
    load_result = win_close && (!out_valid_q || out_ready);
    out_valid_d = out_valid_q;
    rate_out_d  = rate_out_q;
    isi_out_d   = isi_out_q;
    sat_out_d   = sat_out_q;
    overrun_d   = overrun_q;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (load_result) begin
      out_valid_d = 1'b1;
      rate_out_d  = rate_incl;
      isi_out_d   = isi_incl;
      sat_out_d   = sat_incl;
    end
    if (state_q == IDLE) begin
      overrun_d = 1'b0;
    end else if (win_close && out_valid_q && !out_ready) begin
      overrun_d = 1'b1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      spike_q     <= 1'b0;
      win_len_q   <= WIN_ONE;
      win_cnt_q   <= '0;
      isi_last_q  <= '0;
      rate_out_q  <= '0;
      isi_out_q   <= '0;
      sat_out_q   <= 1'b0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      spike_q     <= spike_in;
      win_len_q   <= win_len_d;
      win_cnt_q   <= win_cnt_d;
      isi_last_q  <= isi_last_d;
      rate_out_q  <= rate_out_d;
      isi_out_q   <= isi_out_d;
      sat_out_q   <= sat_out_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rate_out  = rate_out_q;
  assign isi_out   = isi_out_q;
  assign sat_out   = sat_out_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_qif_spike_rate_decoder.sv
// Self-checking bench for qif_spike_rate_decoder: table-driven windows plus
// hand-written multi-cycle sequences, with a scoreboard of expected results.
module tb_qif_spike_rate_decoder;

  localparam int CNT_W = 8;
  localparam int WIN_W = 16;
  localparam int ISI_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic             spike_in = 1'b0;
  logic [WIN_W-1:0] win_len = '0;
  logic             out_ready = 1'b1;
  logic [CNT_W-1:0] rate_out;
  logic [ISI_W-1:0] isi_out;
  logic             sat_out;
  logic             out_valid;
  logic             overrun;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int rate;
    int isi;
    int sat;
    int cyc;   // expected cycle of presentation, -1 = not checked
  } exp_t;

  typedef struct {
    int          len;
    logic [15:0] pat;
    int          rate;
    int          isi;
    int          sat;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[7];

  qif_spike_rate_decoder #(
    .CNT_W (CNT_W),
    .WIN_W (WIN_W),
    .ISI_W (ISI_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .spike_in  (spike_in),
    .win_len   (win_len),
    .rate_out  (rate_out),
    .isi_out   (isi_out),
    .sat_out   (sat_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic push(input int r, input int i, input int s, input int c);
    exp_t e;
    e.rate = r;
    e.isi  = i;
    e.sat  = s;
    e.cyc  = c;
    sb_q.push_back(e);
  endtask

  // Sampled on the falling edge: a transfer happens at the next rising edge.
  task automatic monitor();
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      $display("result cycle=%0d rate=%0d isi=%0d sat=%0d", cyc, rate_out, isi_out, sat_out);
      if (sb_q.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        e = sb_q.pop_front();
        chk("rate_out", int'(rate_out), e.rate);
        chk("isi_out", int'(isi_out), e.isi);
        chk("sat_out", int'(sat_out), e.sat);
        if (e.cyc >= 0) chk("latency_cycle", cyc, e.cyc);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_window(input int n, input logic [15:0] pat);
    for (int w = 0; w < n; w++) begin
      spike_in = pat[w];
      tick();
    end
  endtask

  // Start from IDLE, run one window, and expect its result one cycle after close.
  task automatic run_row(input vec_t v);
    int eff;
    eff = (v.len == 0) ? 1 : v.len;
    en = 1'b0; spike_in = 1'b0; tick();
    en = 1'b1; win_len = WIN_W'(v.len); tick();
    drive_window(eff, v.pat);
    push(v.rate, v.isi, v.sat, cyc);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    //            len  pattern   rate isi sat
    vecs[0] = '{10, 16'h0224, 3, 4,  0};  // edges at 2,5,9
    vecs[1] = '{8,  16'h003E, 1, 0,  0};  // level high 5 cycles
    vecs[2] = '{8,  16'h0055, 4, 2,  0};  // edges at 0,2,4,6
    vecs[3] = '{8,  16'h0088, 2, 4,  0};  // edge on close cycle
    vecs[4] = '{0,  16'h0001, 1, 0,  0};  // length 0 acts as 1
    vecs[5] = '{3,  16'h0000, 0, 0,  0};  // quiet
    vecs[6] = '{16, 16'h8001, 2, 15, 0};  // first and last cycle

    // Reset state.
    tick(); tick();
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_rate_out", int'(rate_out), 0);
    chk("reset_isi_out", int'(isi_out), 0);
    chk("reset_sat_out", int'(sat_out), 0);
    chk("reset_overrun", int'(overrun), 0);
    rst_n = 1'b1;
    tick();

    // Table of single windows.
    for (int k = 0; k < 7; k++) begin
      run_row(vecs[k]);
    end
    en = 1'b0; spike_in = 1'b0; tick();

    // Back-to-back windows: edge right after close lands in the new window.
    en = 1'b1; win_len = 16'd8; tick();
    drive_window(8, 16'h0008);
    push(1, 0, 0, cyc);
    chk("b2b_valid_after_close", int'(out_valid), 1);
    drive_window(1, 16'h0001);
    chk("b2b_valid_one_cycle", int'(out_valid), 0);
    drive_window(7, 16'h0040);
    push(2, 7, 0, cyc);
    drive_window(8, 16'h0000);
    push(0, 7, 0, cyc);
    en = 1'b0; spike_in = 1'b0; tick();

    // Zero length: one result per cycle, ISI carried across them.
    en = 1'b1; win_len = '0; tick();
    spike_in = 1'b1; tick(); push(1, 0, 0, cyc);
    spike_in = 1'b0; tick(); push(0, 0, 0, cyc);
    spike_in = 1'b1; tick(); push(1, 2, 0, cyc);
    spike_in = 1'b1; tick(); push(0, 2, 0, cyc);
    en = 1'b0; spike_in = 1'b0; tick();

    // Saturation window, then a quiet window keeping the last ISI.
    en = 1'b1; win_len = 16'd600; tick();
    for (int w = 0; w < 600; w++) begin
      spike_in = (w % 2) == 1;
      tick();
    end
    push(255, 2, 1, cyc);
    spike_in = 1'b0;
    for (int w = 0; w < 600; w++) tick();
    push(0, 2, 0, cyc);
    en = 1'b0; tick();

    // Back-pressure across two closes.
    out_ready = 1'b0;
    en = 1'b1; win_len = 16'd8; tick();
    drive_window(8, 16'h0002);
    push(1, 0, 0, -1);
    chk("bp_valid_first", int'(out_valid), 1);
    chk("bp_no_overrun_yet", int'(overrun), 0);
    drive_window(8, 16'h0011);
    chk("bp_overrun_set", int'(overrun), 1);
    chk("bp_held_valid", int'(out_valid), 1);
    chk("bp_held_rate", int'(rate_out), 1);
    chk("bp_held_isi", int'(isi_out), 0);
    drive_window(3, 16'h0000);
    out_ready = 1'b1; en = 1'b0; tick();
    chk("bp_valid_drop", int'(out_valid), 0);
    tick();
    chk("bp_overrun_cleared", int'(overrun), 0);

    // Asynchronous reset mid-window with a pending result.
    out_ready = 1'b0;
    en = 1'b1; win_len = 16'd8; tick();
    drive_window(8, 16'h000A);
    chk("pre_reset_valid", int'(out_valid), 1);
    chk("pre_reset_rate", int'(rate_out), 2);
    chk("pre_reset_isi", int'(isi_out), 2);
    drive_window(3, 16'h0002);
    rst_n = 1'b0;
    #1;
    chk("async_reset_valid", int'(out_valid), 0);
    chk("async_reset_rate", int'(rate_out), 0);
    chk("async_reset_isi", int'(isi_out), 0);
    spike_in = 1'b0;
    tick(); tick();
    out_ready = 1'b1; rst_n = 1'b1;
    tick();
    drive_window(8, 16'h0010);
    push(1, 0, 0, cyc);

    // En dropped mid-window: no result for the partial window.
    drive_window(5, 16'h0004);
    en = 1'b0; spike_in = 1'b0;
    tick(); tick(); tick();
    chk("abort_no_valid", int'(out_valid), 0);
    chk("scoreboard_empty", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
